// File: rtl/difficulty_ctrl_if.sv
// Control/status bundle between the game FSM and the difficulty scheduler.
// The master drives the requests and the slave (scheduler) returns the timer-cluster decrement and level status.
interface difficulty_ctrl_if #(
    parameter int unsigned LEVEL_W = 4
);
    logic               start;
    logic               pause;
    logic               game_over;
    logic               tick;
    logic [30:0]        dec;
    logic [LEVEL_W-1:0] level;
    logic               level_up;
    logic               running;
    logic               at_max;

    modport master (
        output start, pause, game_over, tick,
        input  dec, level, level_up, running, at_max
    );

    modport slave (
        input  start, pause, game_over, tick,
        output dec, level, level_up, running, at_max
    );
endinterface

// File: rtl/difficulty_ctrl.sv
// Difficulty scheduler: counts progress ticks, raises the level and steps the shared
// timer decrement up to a saturation ceiling, with start/pause/game-over sequencing.
module difficulty_ctrl #(
    parameter int unsigned TICKS_PER_LEVEL = 10,
    parameter int unsigned DEC_STEP        = 5_000_000,
    parameter int unsigned DEC_MAX         = 90_000_000,
    parameter int unsigned MAX_LEVEL       = 15,
    parameter int unsigned LEVEL_W         = 4
) (
    input  logic              clk,
    input  logic              rst,
    difficulty_ctrl_if.slave  bus
);

    localparam int unsigned DEC_W = 31;
    localparam int unsigned CNT_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICKS_PER_LEVEL - 1);
    localparam logic [31:0]        STEP_32    = 32'(DEC_STEP);
    localparam logic [31:0]        MAX_32     = 32'(DEC_MAX);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(MAX_LEVEL);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_PAUSED = 3'd2;
    localparam logic [2:0] S_MAXED  = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    logic [2:0]         r_state;
    logic [DEC_W-1:0]   r_dec;
    logic [LEVEL_W-1:0] r_level;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_level_up;
    logic               r_running;
    logic               r_at_max;

    logic [2:0]         w_state_nxt;
    logic [DEC_W-1:0]   w_dec_nxt;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_level_up_nxt;
    logic               w_running_nxt;
    logic               w_at_max_nxt;

    logic [31:0]        w_sum;
    logic [DEC_W-1:0]   w_dec_inc;
    logic [LEVEL_W-1:0] w_level_inc;

    // Widened add so the saturation compare sees any carry out of the 31-bit bus.
    assign w_sum       = {1'b0, r_dec} + STEP_32;
    assign w_dec_inc   = (w_sum >= MAX_32) ? DEC_W'(MAX_32) : w_sum[DEC_W-1:0];
    assign w_level_inc = r_level + LEVEL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next register values; priority is game_over > start > pause > tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_dec_nxt      = r_dec;
        w_level_nxt    = r_level;
        w_cnt_nxt      = r_cnt;
        w_level_up_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.game_over) begin
                    w_state_nxt = S_OVER;
                    w_dec_nxt   = '0;
                    w_level_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_dec_nxt   = '0;
                    w_level_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (bus.game_over) begin
                    w_state_nxt = S_OVER;
                end else if (bus.start) begin
                    w_dec_nxt   = '0;
                    w_level_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (bus.pause) begin
                    w_state_nxt = S_PAUSED;
                end else if (bus.tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt      = '0;
                        w_level_nxt    = w_level_inc;
                        w_dec_nxt      = w_dec_inc;
                        w_level_up_nxt = 1'b1;
                        if ((w_level_inc == LEVEL_LAST) || (w_dec_inc == DEC_W'(MAX_32))) begin
                            w_state_nxt = S_MAXED;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_PAUSED: begin
                if (bus.game_over) begin
                    w_state_nxt = S_OVER;
                end else if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_dec_nxt   = '0;
                    w_level_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (!bus.pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_MAXED: begin
                if (bus.game_over) begin
                    w_state_nxt = S_OVER;
                end else if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_dec_nxt   = '0;
                    w_level_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_OVER: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_dec_nxt   = '0;
                    w_level_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dec_nxt   = '0;
                w_level_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_running_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_MAXED);
    assign w_at_max_nxt  = (w_state_nxt == S_MAXED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec      <= '0;
            r_level    <= '0;
            r_cnt      <= '0;
            r_level_up <= 1'b0;
            r_running  <= 1'b0;
            r_at_max   <= 1'b0;
        end else begin
            r_dec      <= w_dec_nxt;
            r_level    <= w_level_nxt;
            r_cnt      <= w_cnt_nxt;
            r_level_up <= w_level_up_nxt;
            r_running  <= w_running_nxt;
            r_at_max   <= w_at_max_nxt;
        end
    end

    assign bus.dec      = r_dec;
    assign bus.level    = r_level;
    assign bus.level_up = r_level_up;
    assign bus.running  = r_running;
    assign bus.at_max   = r_at_max;

endmodule
